// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state encoding
// and the default address / cycle-counter widths.
package pc_sequencer_pkg;

    // Default program-counter and branch-target width
    localparam int DEFAULT_D  = 10;
    // Default run-cycle counter width
    localparam int DEFAULT_CW = 16;

    // Sequencer control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter sequencer. It starts at pc 0 on start and then steps pc by
// increment, stall or branch. Branch targets come from an external
// combinational table that is addressed by lut_addr. Execution stops on
// halt_req. A saturating counter records how many cycles were spent in RUN.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int D  = DEFAULT_D,
    parameter int CW = DEFAULT_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stall,
    input  logic          halt_req,
    input  logic          branch_en,
    input  logic          taken,
    input  logic          branch_rel,
    input  logic [3:0]    branch_idx,
    input  logic [D-1:0]  lut_target,
    output logic [3:0]    lut_addr,
    output logic [D-1:0]  pc,
    output logic          running,
    output logic          done,
    output logic [CW-1:0] cycles
);

    state_t        state_reg, state_next;
    logic [D-1:0]  pc_reg, pc_next;
    logic [CW-1:0] cycles_reg, cycles_next;

    // The target table is looked up in the same cycle, so its index passes straight through
    assign lut_addr = branch_idx;

    // State, pc and cycle counter registers; reset clears them without waiting for a clock edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            pc_reg     <= '0;
            cycles_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            cycles_reg <= cycles_next;
        end
    end

    // Next-state, next-pc and next-count logic; in RUN the priority is halt > stall > taken branch > increment
    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        cycles_next = cycles_reg;
        case (state_reg)
            IDLE, HALT: begin
                if (start) begin
                    state_next  = RUN;
                    pc_next     = '0;
                    cycles_next = '0;
                end
            end
            RUN: begin
                // Every RUN cycle counts, including stall and halt cycles
                if (cycles_reg != {CW{1'b1}}) begin
                    cycles_next = cycles_reg + CW'(1);
                end
                if (halt_req) begin
                    state_next = HALT;
                end else if (stall) begin
                    pc_next = pc_reg;
                end else if (branch_en && taken) begin
                    // A relative target is a D-bit two's-complement offset, so
                    // wrap-around addition gives the signed result
                    pc_next = branch_rel ? (pc_reg + lut_target) : lut_target;
                end else begin
                    pc_next = pc_reg + D'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The status outputs are decoded from registered state only
    assign pc      = pc_reg;
    assign cycles  = cycles_reg;
    assign running = (state_reg == RUN);
    assign done    = (state_reg == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer. It holds the target table used by the
// bench. One instance uses the default widths. A second instance has CW=4,
// shares all inputs, and is used to observe counter saturation.
module tb_pc_sequencer;

    localparam int D = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, stall, halt_req, branch_en, taken, branch_rel;
    logic [3:0]    branch_idx;
    logic [D-1:0]  lut_target, lut_target_s;
    logic [3:0]    lut_addr, lut_addr_s;
    logic [D-1:0]  pc, pc_s;
    logic          running, done, running_s, done_s;
    logic [15:0]   cycles;
    logic [3:0]    cycles_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Bench target table, driven from each DUT's own lut_addr
    function automatic logic [D-1:0] table_lookup(input logic [3:0] a);
        case (a)
            4'd1:    return 10'd11;
            4'd2:    return 10'd44;
            4'd3:    return 10'd105;
            4'd4:    return 10'd1023;
            4'd9:    return 10'd20;
            default: return 10'd0;
        endcase
    endfunction

    assign lut_target   = table_lookup(lut_addr);
    assign lut_target_s = table_lookup(lut_addr_s);

    pc_sequencer #(.D(D), .CW(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
        .branch_en(branch_en), .taken(taken), .branch_rel(branch_rel),
        .branch_idx(branch_idx), .lut_target(lut_target), .lut_addr(lut_addr),
        .pc(pc), .running(running), .done(done), .cycles(cycles)
    );

    pc_sequencer #(.D(D), .CW(4)) dut_s (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
        .branch_en(branch_en), .taken(taken), .branch_rel(branch_rel),
        .branch_idx(branch_idx), .lut_target(lut_target_s), .lut_addr(lut_addr_s),
        .pc(pc_s), .running(running_s), .done(done_s), .cycles(cycles_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; stall = 0; halt_req = 0; branch_en = 0;
        taken = 0; branch_rel = 0; branch_idx = 4'd0;
    endtask

    // Reset pulse between edges, start pulse, then n plain RUN cycles -> pc == n
    task automatic go_to_pc(input int n);
        clear_inputs();
        reset = 1; #2; reset = 0;
        start = 1; step(); start = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        branch_idx = 4'd3;
        #1;
        total++; if (pc !== 10'd0)        begin bad++; $display("FAIL reset_pc got=%0d want=0", pc); end
        total++; if (cycles !== 16'd0)    begin bad++; $display("FAIL reset_cycles got=%0d want=0", cycles); end
        total++; if (running !== 1'b0)    begin bad++; $display("FAIL reset_running got=%b want=0", running); end
        total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (lut_addr !== 4'd3)   begin bad++; $display("FAIL reset_lut_addr got=%0d want=3", lut_addr); end
        branch_idx = 4'd9; #1;
        total++; if (lut_addr !== 4'd9)   begin bad++; $display("FAIL reset_lut_track got=%0d want=9", lut_addr); end
        step(); step();
        // start held during reset must have no effect
        start = 1; step(); start = 0;
        total++; if (running !== 1'b0)    begin bad++; $display("FAIL reset_hold_running got=%b want=0", running); end
        reset = 0;
        step();
        total++; if (running !== 1'b0 || pc !== 10'd0) begin bad++; $display("FAIL idle_stays got run=%b pc=%0d want run=0 pc=0", running, pc); end
        // Inputs other than start are ignored in IDLE
        stall = 1; branch_en = 1; taken = 1; branch_idx = 4'd2; step(); clear_inputs();
        total++; if (running !== 1'b0 || pc !== 10'd0) begin bad++; $display("FAIL idle_ignore got run=%b pc=%0d want run=0 pc=0", running, pc); end
        $display("test_reset: pc=%0d cycles=%0d running=%b done=%b", pc, cycles, running, done);
    endtask

    task automatic test_plain_run();
        clear_inputs();
        start = 1; step(); start = 0;
        total++; if (running !== 1'b1 || pc !== 10'd0 || cycles !== 16'd0) begin bad++; $display("FAIL start got run=%b pc=%0d cyc=%0d want run=1 pc=0 cyc=0", running, pc, cycles); end
        for (int i = 1; i <= 5; i++) begin
            step();
            total++; if (pc !== 10'(i)) begin bad++; $display("FAIL plain_pc got=%0d want=%0d", pc, i); end
        end
        total++; if (running !== 1'b1)   begin bad++; $display("FAIL plain_running got=%b want=1", running); end
        total++; if (cycles !== 16'd5)   begin bad++; $display("FAIL plain_cycles got=%0d want=5", cycles); end
        // start in RUN is ignored: pc keeps incrementing
        start = 1; step(); start = 0;
        total++; if (pc !== 10'd6 || cycles !== 16'd6) begin bad++; $display("FAIL start_in_run got pc=%0d cyc=%0d want pc=6 cyc=6", pc, cycles); end
        $display("test_plain_run: pc=%0d cycles=%0d", pc, cycles);
    endtask

    task automatic test_branch_abs();
        go_to_pc(7);
        total++; if (pc !== 10'd7) begin bad++; $display("FAIL abs_setup got=%0d want=7", pc); end
        branch_en = 1; taken = 1; branch_rel = 0; branch_idx = 4'd2; step(); clear_inputs();
        total++; if (pc !== 10'd44) begin bad++; $display("FAIL abs_taken got=%0d want=44", pc); end
        go_to_pc(7);
        branch_en = 1; taken = 0; branch_rel = 0; branch_idx = 4'd2; step(); clear_inputs();
        total++; if (pc !== 10'd8) begin bad++; $display("FAIL abs_not_taken got=%0d want=8", pc); end
        // taken without branch_en must not branch
        branch_en = 0; taken = 1; branch_rel = 1; branch_idx = 4'd3; step(); clear_inputs();
        total++; if (pc !== 10'd9) begin bad++; $display("FAIL no_branch_en got=%0d want=9", pc); end
        branch_en = 1; taken = 1; branch_rel = 0; branch_idx = 4'd3; step(); clear_inputs();
        total++; if (pc !== 10'd105) begin bad++; $display("FAIL abs_idx3 got=%0d want=105", pc); end
        $display("test_branch_abs: pc=%0d", pc);
    endtask

    task automatic test_branch_rel();
        go_to_pc(30);
        branch_en = 1; taken = 1; branch_rel = 1; branch_idx = 4'd9; step(); clear_inputs();
        total++; if (pc !== 10'd50) begin bad++; $display("FAIL rel_plus20 got=%0d want=50", pc); end
        go_to_pc(30);
        branch_en = 1; taken = 1; branch_rel = 1; branch_idx = 4'd4; step(); clear_inputs();
        total++; if (pc !== 10'd29) begin bad++; $display("FAIL rel_minus1 got=%0d want=29", pc); end
        branch_en = 1; taken = 1; branch_rel = 0; branch_idx = 4'd4; step(); clear_inputs();
        total++; if (pc !== 10'd1023) begin bad++; $display("FAIL abs_to_max got=%0d want=1023", pc); end
        step();
        total++; if (pc !== 10'd0) begin bad++; $display("FAIL wrap got=%0d want=0", pc); end
        $display("test_branch_rel: pc=%0d", pc);
    endtask

    task automatic test_stall_halt();
        go_to_pc(12);
        stall = 1; branch_en = 1; taken = 1; branch_idx = 4'd2; step(); clear_inputs();
        total++; if (pc !== 10'd12) begin bad++; $display("FAIL stall_over_branch got=%0d want=12", pc); end
        total++; if (cycles !== 16'd13) begin bad++; $display("FAIL stall_cycles got=%0d want=13", cycles); end
        halt_req = 1; stall = 1; step(); clear_inputs();
        total++; if (done !== 1'b1 || running !== 1'b0) begin bad++; $display("FAIL halt_state got done=%b run=%b want done=1 run=0", done, running); end
        total++; if (pc !== 10'd12) begin bad++; $display("FAIL halt_pc got=%0d want=12", pc); end
        total++; if (cycles !== 16'd14) begin bad++; $display("FAIL halt_cycles got=%0d want=14", cycles); end
        step(); step();
        total++; if (pc !== 10'd12 || cycles !== 16'd14 || done !== 1'b1) begin bad++; $display("FAIL halt_hold got pc=%0d cyc=%0d done=%b want pc=12 cyc=14 done=1", pc, cycles, done); end
        $display("test_stall_halt: pc=%0d cycles=%0d done=%b", pc, cycles, done);
    endtask

    task automatic test_restart_from_halt();
        start = 1; step(); start = 0;
        total++; if (running !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL restart_state got run=%b done=%b want run=1 done=0", running, done); end
        total++; if (pc !== 10'd0 || cycles !== 16'd0) begin bad++; $display("FAIL restart_vals got pc=%0d cyc=%0d want pc=0 cyc=0", pc, cycles); end
        step();
        total++; if (pc !== 10'd1) begin bad++; $display("FAIL restart_step got=%0d want=1", pc); end
        $display("test_restart_from_halt: pc=%0d cycles=%0d", pc, cycles);
    endtask

    task automatic test_reset_mid_run();
        go_to_pc(20);
        total++; if (pc !== 10'd20) begin bad++; $display("FAIL midrun_setup got=%0d want=20", pc); end
        #2; reset = 1; #1;
        // Checked between clock edges: reset acts without a clock
        total++; if (pc !== 10'd0 || running !== 1'b0 || cycles !== 16'd0) begin bad++; $display("FAIL async_reset got pc=%0d run=%b cyc=%0d want 0/0/0", pc, running, cycles); end
        reset = 0;
        step();
        total++; if (running !== 1'b0 || pc !== 10'd0) begin bad++; $display("FAIL after_reset_idle got run=%b pc=%0d want run=0 pc=0", running, pc); end
        start = 1; step(); start = 0;
        total++; if (running !== 1'b1 || pc !== 10'd0) begin bad++; $display("FAIL after_reset_start got run=%b pc=%0d want run=1 pc=0", running, pc); end
        $display("test_reset_mid_run: pc=%0d running=%b", pc, running);
    endtask

    task automatic test_saturate();
        go_to_pc(20);
        total++; if (cycles_s !== 4'd15) begin bad++; $display("FAIL sat_cw4 got=%0d want=15", cycles_s); end
        total++; if (cycles !== 16'd20) begin bad++; $display("FAIL cw16_count got=%0d want=20", cycles); end
        total++; if (pc_s !== 10'd20) begin bad++; $display("FAIL sat_pc got=%0d want=20", pc_s); end
        $display("test_saturate: cycles_cw4=%0d cycles_cw16=%0d", cycles_s, cycles);
    endtask

    initial begin
        test_reset();
        test_plain_run();
        test_branch_abs();
        test_branch_rel();
        test_stall_halt();
        test_restart_from_halt();
        test_reset_mid_run();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
